// File: rtl/mux_nto1_stream.sv
// N:1 word multiplexer with valid/ready on every channel, addressed or round-robin selection and one output register.
// Optional: define MUX_STALL_CNT_EN to add a saturating 16-bit stall_cnt output.
module mux_nto1_stream #(
    parameter int WIDTH = 32,
    parameter int N     = 32,
    parameter int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mode,
    input  logic [SELW-1:0]      address,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_src
`ifdef MUX_STALL_CNT_EN
   ,output logic [15:0]          stall_cnt
`endif
);

    localparam logic [SELW:0]   N_EXT    = (SELW+1)'(N);
    localparam logic [SELW-1:0] LAST_IDX = SELW'(N - 1);

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  out_src_q,   out_src_d;
    logic [SELW-1:0]  rr_last_q,   rr_last_d;

    logic             rr_found;
    logic [SELW-1:0]  rr_idx;
    logic [SELW-1:0]  rr_cand;
    logic             grant_valid;
    logic [SELW-1:0]  grant_idx;
    logic             load;
    logic             transfer;
    logic [WIDTH-1:0] sel_data;

    // Scan starts one past the last round-robin winner and wraps modulo N, so non-power-of-two N works.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = rr_last_q;
        rr_cand  = '0;
        for (int i = 1; i <= N; i++) begin
            rr_cand = SELW'((int'(rr_last_q) + i) % N);
            if (!rr_found && in_valid[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (mode) begin
            grant_valid = rr_found;
            grant_idx   = rr_idx;
        end else if (({1'b0, address} < N_EXT) && in_valid[address]) begin
            grant_valid = 1'b1;
            grant_idx   = address;
        end
    end

    assign load     = !out_valid_q || out_ready;
    assign transfer = grant_valid && load;
    assign sel_data = in_data[grant_idx*WIDTH +: WIDTH];

    always_comb begin
        in_ready = '0;
        if (transfer) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // A drain with no simultaneous transfer clears valid but keeps the last data and source.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_src_d   = out_src_q;
        rr_last_d   = rr_last_q;
        if (transfer) begin
            out_data_d  = sel_data;
            out_valid_d = 1'b1;
            out_src_d   = grant_idx;
            if (mode) begin
                rr_last_d = grant_idx;
            end
        end else if (load) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
            rr_last_q   <= LAST_IDX;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
            rr_last_q   <= rr_last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;

`ifdef MUX_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
